// File: rtl/npu_act_mem_wr_arbiter_if.sv
// rtl/npu_act_mem_wr_arbiter_if.sv - request/ack, memory write port and status bundle for the activation memory write arbiter
interface npu_act_mem_wr_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int CNT_WIDTH  = 16
) ();
    // NPU post-processing writer
    logic                  hw_wr_req;
    logic [ADDR_WIDTH-1:0] hw_wr_addr;
    logic [DATA_WIDTH-1:0] hw_wr_data;
    logic                  hw_wr_ack_p;
    // host loader
    logic                  host_wr_req;
    logic [ADDR_WIDTH-1:0] host_wr_addr;
    logic [DATA_WIDTH-1:0] host_wr_data;
    logic                  host_wr_ack_p;
    logic                  host_wr_enable;
    // activation memory write port
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    // status / control
    logic                  clr_cnt_p;
    logic [CNT_WIDTH-1:0]  hw_wr_cnt;
    logic [CNT_WIDTH-1:0]  host_wr_cnt;
    logic                  addr_err;

    // requester / control side
    modport master (
        output hw_wr_req, hw_wr_addr, hw_wr_data,
        output host_wr_req, host_wr_addr, host_wr_data, host_wr_enable,
        output clr_cnt_p,
        input  hw_wr_ack_p, host_wr_ack_p,
        input  mem_we, mem_addr, mem_wdata,
        input  hw_wr_cnt, host_wr_cnt, addr_err
    );

    // arbiter side
    modport slave (
        input  hw_wr_req, hw_wr_addr, hw_wr_data,
        input  host_wr_req, host_wr_addr, host_wr_data, host_wr_enable,
        input  clr_cnt_p,
        output hw_wr_ack_p, host_wr_ack_p,
        output mem_we, mem_addr, mem_wdata,
        output hw_wr_cnt, host_wr_cnt, addr_err
    );
endinterface

// File: rtl/npu_act_mem_wr_arbiter.sv
// rtl/npu_act_mem_wr_arbiter.sv - round-robin arbiter for the activation memory write port (NPU vs host)
module npu_act_mem_wr_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 12,
    parameter int ACT_MEM_DEPTH = 4096,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    npu_act_mem_wr_arbiter_if.slave  bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [32:0]          DEPTH_EXT = 33'(ACT_MEM_DEPTH);

    logic                  r_hw_ack;
    logic                  r_host_ack;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_last_grant_host;
    logic [CNT_WIDTH-1:0]  r_hw_cnt;
    logic [CNT_WIDTH-1:0]  r_host_cnt;
    logic                  r_addr_err;

    logic                  w_hw_elig;
    logic                  w_host_elig;
    logic                  w_grant_hw;
    logic                  w_grant_host;
    logic                  w_grant_any;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic [DATA_WIDTH-1:0] w_win_data;
    logic                  w_in_range;

    // A requester still sees its own ack in the ack cycle and keeps its request
    // high for that cycle, so the registered ack masks it from re-arbitration.
    assign w_hw_elig   = bus.hw_wr_req & ~r_hw_ack;
    assign w_host_elig = bus.host_wr_req & bus.host_wr_enable & ~r_host_ack;

    // Round-robin between the two: on a tie the side that did not win last time goes.
    assign w_grant_hw   = w_hw_elig   & (~w_host_elig | r_last_grant_host);
    assign w_grant_host = w_host_elig & (~w_hw_elig   | ~r_last_grant_host);
    assign w_grant_any  = w_grant_hw | w_grant_host;

    // Winner's write request, zero-extended so any ADDR_WIDTH compares safely against the depth.
    always_comb begin
        w_win_addr = bus.hw_wr_addr;
        w_win_data = bus.hw_wr_data;
        if (w_grant_host) begin
            w_win_addr = bus.host_wr_addr;
            w_win_data = bus.host_wr_data;
        end
    end
    assign w_in_range = (33'(w_win_addr) < DEPTH_EXT);

    // Register the grant: acks, memory write strobe/address/data and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hw_ack          <= 1'b0;
            r_host_ack        <= 1'b0;
            r_mem_we          <= 1'b0;
            r_mem_addr        <= '0;
            r_mem_wdata       <= '0;
            r_last_grant_host <= 1'b1;
        end else begin
            r_hw_ack   <= w_grant_hw;
            r_host_ack <= w_grant_host;
            r_mem_we   <= w_grant_any & w_in_range;
            if (w_grant_any && w_in_range) begin
                r_mem_addr  <= w_win_addr;
                r_mem_wdata <= w_win_data;
            end
            if (w_grant_any) begin
                r_last_grant_host <= w_grant_host;
            end
        end
    end

    // Saturating write counters and sticky range error; a clear in the same cycle wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hw_cnt   <= '0;
            r_host_cnt <= '0;
            r_addr_err <= 1'b0;
        end else if (bus.clr_cnt_p) begin
            r_hw_cnt   <= '0;
            r_host_cnt <= '0;
            r_addr_err <= 1'b0;
        end else begin
            if (w_grant_hw && w_in_range && (r_hw_cnt != CNT_MAX)) begin
                r_hw_cnt <= r_hw_cnt + CNT_WIDTH'(1);
            end
            if (w_grant_host && w_in_range && (r_host_cnt != CNT_MAX)) begin
                r_host_cnt <= r_host_cnt + CNT_WIDTH'(1);
            end
            if (w_grant_any && !w_in_range) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    assign bus.hw_wr_ack_p   = r_hw_ack;
    assign bus.host_wr_ack_p = r_host_ack;
    assign bus.mem_we        = r_mem_we;
    assign bus.mem_addr      = r_mem_addr;
    assign bus.mem_wdata     = r_mem_wdata;
    assign bus.hw_wr_cnt     = r_hw_cnt;
    assign bus.host_wr_cnt   = r_host_cnt;
    assign bus.addr_err      = r_addr_err;
endmodule

// File: tb/tb_npu_act_mem_wr_arbiter.sv
// tb/tb_npu_act_mem_wr_arbiter.sv - self-checking bench for the activation memory write arbiter
module tb_npu_act_mem_wr_arbiter;
    localparam int DW      = 8;
    localparam int AW      = 13;
    localparam int DEPTH   = 4096;
    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int NV      = 6;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            we;
    } wr_t;

    typedef struct {
        bit            host;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            exp_we;
        bit            exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    npu_act_mem_wr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    npu_act_mem_wr_arbiter #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .ACT_MEM_DEPTH(DEPTH),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int            checks   = 0;
    int            failures = 0;
    wr_t           hw_q[$];
    wr_t           host_q[$];
    int            ack_log[$];
    int            exp_hw_cnt   = 0;
    int            exp_host_cnt = 0;
    bit            exp_err      = 1'b0;
    logic [AW-1:0] last_addr    = '0;
    logic [DW-1:0] last_data    = '0;
    bit            clr_edge     = 1'b0;
    vec_t          vt[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] dval(input int a);
        return DW'(a * 7 + 3);
    endfunction

    task automatic issue_hw(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit we);
        wr_t e;
        bus.hw_wr_req  = 1'b1;
        bus.hw_wr_addr = a;
        bus.hw_wr_data = d;
        e.addr = a; e.data = d; e.we = we;
        hw_q.push_back(e);
    endtask

    task automatic issue_host(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit we);
        wr_t e;
        bus.host_wr_req  = 1'b1;
        bus.host_wr_addr = a;
        bus.host_wr_data = d;
        e.addr = a; e.data = d; e.we = we;
        host_q.push_back(e);
    endtask

    task automatic traffic(input int n_hw, input int hw_base, input int n_host, input int host_base, input int budget);
        int hi  = 0;
        int si  = 0;
        int cyc = 0;
        if (n_hw > 0)   issue_hw(AW'(hw_base), dval(hw_base), (hw_base < DEPTH));
        if (n_host > 0) issue_host(AW'(host_base), dval(host_base), (host_base < DEPTH));
        while ((hi < n_hw || si < n_host) && cyc < budget) begin
            tick();
            cyc++;
            if (bus.hw_wr_ack_p && hi < n_hw) begin
                hi++;
                if (hi < n_hw) issue_hw(AW'(hw_base + hi), dval(hw_base + hi), ((hw_base + hi) < DEPTH));
                else           bus.hw_wr_req = 1'b0;
            end
            if (bus.host_wr_ack_p && si < n_host) begin
                si++;
                if (si < n_host) issue_host(AW'(host_base + si), dval(host_base + si), ((host_base + si) < DEPTH));
                else             bus.host_wr_req = 1'b0;
            end
        end
        check("traffic_complete", 32'(hi + si), 32'(n_hw + n_host));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // clear request as seen by the DUT at the active edge
    always @(posedge clk) clr_edge = bus.clr_cnt_p;

    // Scoreboard: every ack pops the owner's expected write; counters and error tracked by the model.
    always @(negedge clk) begin
        wr_t e;
        bit  got;
        bit  is_host;
        if (!rst) begin
            exp_hw_cnt   = 0;
            exp_host_cnt = 0;
            exp_err      = 1'b0;
            last_addr    = '0;
            last_data    = '0;
        end else begin
            got     = 1'b0;
            is_host = 1'b0;
            check("ack_mutex", 32'(bus.hw_wr_ack_p & bus.host_wr_ack_p), 0);
            if (bus.hw_wr_ack_p) begin
                ack_log.push_back(0);
                check("hw_ack_expected", 32'(hw_q.size() != 0), 1);
                if (hw_q.size() != 0) begin e = hw_q.pop_front(); got = 1'b1; end
            end else if (bus.host_wr_ack_p) begin
                ack_log.push_back(1);
                is_host = 1'b1;
                check("host_ack_expected", 32'(host_q.size() != 0), 1);
                if (host_q.size() != 0) begin e = host_q.pop_front(); got = 1'b1; end
            end
            if (got) begin
                check("mem_we", 32'(bus.mem_we), 32'(e.we));
                if (e.we) begin
                    check("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
                    check("mem_wdata", 32'(bus.mem_wdata), 32'(e.data));
                    last_addr = e.addr;
                    last_data = e.data;
                end
                if (!clr_edge) begin
                    if (!e.we)                           exp_err = 1'b1;
                    else if (is_host && exp_host_cnt != CNT_MAX) exp_host_cnt++;
                    else if (!is_host && exp_hw_cnt != CNT_MAX)  exp_hw_cnt++;
                end
            end
            if (clr_edge) begin
                exp_hw_cnt   = 0;
                exp_host_cnt = 0;
                exp_err      = 1'b0;
            end
            if (!bus.mem_we) begin
                check("mem_addr_hold", 32'(bus.mem_addr), 32'(last_addr));
                check("mem_wdata_hold", 32'(bus.mem_wdata), 32'(last_data));
            end
            check("hw_wr_cnt", 32'(bus.hw_wr_cnt), 32'(exp_hw_cnt));
            check("host_wr_cnt", 32'(bus.host_wr_cnt), 32'(exp_host_cnt));
            check("addr_err", 32'(bus.addr_err), 32'(exp_err));
        end
    end

    initial begin
        int n;
        vt[0] = '{host: 1'b0, addr: 13'h0010, data: 8'h5A, exp_we: 1'b1, exp_err: 1'b0};
        vt[1] = '{host: 1'b1, addr: 13'h0FFF, data: 8'h3C, exp_we: 1'b1, exp_err: 1'b0};
        vt[2] = '{host: 1'b0, addr: 13'h0FFF, data: 8'hC3, exp_we: 1'b1, exp_err: 1'b0};
        vt[3] = '{host: 1'b1, addr: 13'h1000, data: 8'h11, exp_we: 1'b0, exp_err: 1'b1};
        vt[4] = '{host: 1'b0, addr: 13'h1FFF, data: 8'h22, exp_we: 1'b0, exp_err: 1'b1};
        vt[5] = '{host: 1'b0, addr: 13'h0000, data: 8'h00, exp_we: 1'b1, exp_err: 1'b1};

        bus.hw_wr_req = 1'b0; bus.hw_wr_addr = '0; bus.hw_wr_data = '0;
        bus.host_wr_req = 1'b0; bus.host_wr_addr = '0; bus.host_wr_data = '0;
        bus.host_wr_enable = 1'b1;
        bus.clr_cnt_p = 1'b0;

        // reset state
        tick();
        check("rst_hw_ack", 32'(bus.hw_wr_ack_p), 0);
        check("rst_host_ack", 32'(bus.host_wr_ack_p), 0);
        check("rst_mem_we", 32'(bus.mem_we), 0);
        check("rst_mem_addr", 32'(bus.mem_addr), 0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 0);
        check("rst_hw_cnt", 32'(bus.hw_wr_cnt), 0);
        check("rst_host_cnt", 32'(bus.host_wr_cnt), 0);
        check("rst_addr_err", 32'(bus.addr_err), 0);
        tick();
        rst = 1'b1;

        // both requesting continuously from reset: NPU, HOST, NPU, ...
        ack_log.delete();
        tick();
        traffic(4, 'h100, 4, 'h200, 40);
        check("rr_ack_count", 32'(ack_log.size()), 8);
        for (int i = 0; i < ack_log.size() && i < 8; i++) check("rr_order", 32'(ack_log[i]), 32'(i % 2));
        check("rr_hw_cnt", 32'(bus.hw_wr_cnt), 4);
        check("rr_host_cnt", 32'(bus.host_wr_cnt), 4);

        // table of single writes, including range boundaries and sticky error
        for (int i = 0; i < NV; i++) begin
            tick();
            if (vt[i].host) issue_host(vt[i].addr, vt[i].data, vt[i].exp_we);
            else            issue_hw(vt[i].addr, vt[i].data, vt[i].exp_we);
            n = 0;
            do begin tick(); n++; end while (!(bus.hw_wr_ack_p | bus.host_wr_ack_p) && n < 8);
            check("tbl_latency", 32'(n), 1);
            check("tbl_ack_owner", 32'(bus.host_wr_ack_p), 32'(vt[i].host));
            check("tbl_mem_we", 32'(bus.mem_we), 32'(vt[i].exp_we));
            check("tbl_addr_err", 32'(bus.addr_err), 32'(vt[i].exp_err));
            bus.hw_wr_req   = 1'b0;
            bus.host_wr_req = 1'b0;
            tick();
            check("tbl_no_regrant", 32'(bus.hw_wr_ack_p | bus.host_wr_ack_p), 0);
        end

        // clear pulse drops the sticky error and counters
        bus.clr_cnt_p = 1'b1;
        tick();
        bus.clr_cnt_p = 1'b0;
        check("clr_addr_err", 32'(bus.addr_err), 0);
        check("clr_hw_cnt", 32'(bus.hw_wr_cnt), 0);
        check("clr_host_cnt", 32'(bus.host_wr_cnt), 0);

        // masked host request stays pending while NPU traffic flows
        tick();
        bus.host_wr_enable = 1'b0;
        issue_host(13'h0300, 8'h77, 1'b1);
        traffic(5, 'h400, 0, 0, 40);
        repeat (12) tick();
        check("mask_host_pending", 32'(host_q.size()), 1);
        check("mask_hw_cnt", 32'(bus.hw_wr_cnt), 5);
        check("mask_host_cnt", 32'(bus.host_wr_cnt), 0);
        bus.host_wr_enable = 1'b1;
        tick();
        check("unmask_host_ack", 32'(bus.host_wr_ack_p), 1);
        bus.host_wr_req = 1'b0;

        // counter saturation
        tick();
        traffic(CNT_MAX + 5, 'h500, 0, 0, 2 * CNT_MAX + 40);
        tick();
        check("sat_hw_cnt", 32'(bus.hw_wr_cnt), 32'(CNT_MAX));

        // clear concurrent with a granted write: clear wins
        issue_hw(13'h0020, 8'h99, 1'b1);
        bus.clr_cnt_p = 1'b1;
        tick();
        bus.clr_cnt_p = 1'b0;
        check("clr_win_ack", 32'(bus.hw_wr_ack_p), 1);
        check("clr_win_hw_cnt", 32'(bus.hw_wr_cnt), 0);
        bus.hw_wr_req = 1'b0;

        // reset in the grant cycle drops the write; held request is re-arbitrated
        tick();
        issue_hw(13'h0030, 8'h44, 1'b1);
        rst = 1'b0;
        tick();
        check("rstmid_ack", 32'(bus.hw_wr_ack_p), 0);
        check("rstmid_mem_we", 32'(bus.mem_we), 0);
        check("rstmid_hw_cnt", 32'(bus.hw_wr_cnt), 0);
        check("rstmid_host_cnt", 32'(bus.host_wr_cnt), 0);
        rst = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!bus.hw_wr_ack_p && n < 6);
        check("rstmid_reack_within_2", 32'(n <= 2), 1);
        bus.hw_wr_req = 1'b0;
        tick();
        check("rstmid_hw_cnt_after", 32'(bus.hw_wr_cnt), 1);

        tick();
        check("hw_q_drained", 32'(hw_q.size()), 0);
        check("host_q_drained", 32'(host_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
